mem_bus_interface: RTL and testbench

CPU-side memory bus master for the 16-bit multicycle CPU. It sits between the control unit and `memoryModule`. It accepts single-word read and write requests through a req/done handshake and latches address and write data (MAR/MDR role). It then drives `Abus`, `Dbus`, `rdM` and `wrM`, waits for the memory's `mfc` completion signal, captures read data, and reports completion or a timeout error.

---
 rtl/mem_if_pkg.sv | 32 +++
 rtl/mfc_sync.sv | 26 ++
 rtl/mem_bus_interface.sv | 144 ++++++++++++++
 tb/tb_mem_bus_interface.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the CPU-side memory bus master.
package mem_if_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // True while a transfer owns the bus (address/data/strobe phases).
    function automatic logic is_bus_phase(input state_t s);
        return (s == ST_SETUP) || (s == ST_STROBE) ||
               (s == ST_WAIT_LOW) || (s == ST_WAIT_HIGH);
    endfunction

    function automatic logic is_strobe_phase(input state_t s);
        return (s == ST_STROBE) || (s == ST_WAIT_LOW) || (s == ST_WAIT_HIGH);
    endfunction

endpackage

// File: rtl/mfc_sync.sv
// Flop-chain synchronizer for the asynchronous memory-function-complete signal.
module mfc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/mem_bus_interface.sv
// Single-word memory bus master: latches a request (MAR/MDR), runs the
// strobe / mfc handshake against memoryModule, and reports done or timeout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for req; latches addr/wdata/we on acceptance
// SETUP      | Abus (and Dbus on writes) driven, strobes low
// STROBE     | rdM/wrM high, timeout counter cleared
// WAIT_LOW   | strobe held until synchronized mfc goes low
// WAIT_HIGH  | strobe held until mfc returns high; read data captured
// DONE       | one-cycle done pulse
// ERR        | one-cycle err pulse after timeout
module mem_bus_interface
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] Abus,
    inout  wire  [DATA_W-1:0] Dbus,
    output logic              rdM,
    output logic              wrM,
    input  logic              mfc
);

    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    op_t               r_op;
    op_t               w_op_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdM;
    logic              r_wrM;
    logic              r_dbus_oe;
    logic              w_mfc_s;
    logic              w_accept;
    logic              w_timeout;
    logic              w_capture;
    logic              w_next_strobe;
    logic              w_next_drive;

    mfc_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_mfc_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(mfc),
        .o_sync (w_mfc_s)
    );

    assign w_accept  = (r_state == ST_IDLE) && req;
    assign w_op_next = w_accept ? op_t'(we) : r_op;
    assign w_timeout = (r_cnt == CNT_LAST);

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE:      if (req) w_next_state = ST_SETUP;
            ST_SETUP:     w_next_state = ST_STROBE;
            ST_STROBE:    w_next_state = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                // Timeout wins over an mfc edge seen in the same cycle.
                if (w_timeout)     w_next_state = ST_ERR;
                else if (!w_mfc_s) w_next_state = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (w_timeout) begin
                    w_next_state = ST_ERR;
                end else if (w_mfc_s) begin
                    w_next_state = ST_DONE;
                    w_capture    = (r_op == OP_READ);
                end
            end
            ST_DONE:      w_next_state = ST_IDLE;
            ST_ERR:       w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Strobes and bus enable are registered from the next state so they
    // change cleanly on the clock edge and fall together.
    assign w_next_strobe = is_strobe_phase(w_next_state);
    assign w_next_drive  = is_bus_phase(w_next_state) && (w_op_next == OP_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_op      <= OP_READ;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_rdM     <= 1'b0;
            r_wrM     <= 1'b0;
            r_dbus_oe <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_mar <= addr;
                r_mdr <= wdata;
                r_op  <= op_t'(we);
            end
            if (r_state == ST_STROBE) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HIGH)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_rdata <= Dbus;
            end
            r_rdM     <= w_next_strobe && (w_op_next == OP_READ);
            r_wrM     <= w_next_strobe && (w_op_next == OP_WRITE);
            r_dbus_oe <= w_next_drive;
        end
    end

    assign Dbus  = r_dbus_oe ? r_mdr : {DATA_W{1'bz}};
    assign Abus  = r_mar;
    assign rdata = r_rdata;
    assign rdM   = r_rdM;
    assign wrM   = r_wrM;
    assign busy  = is_bus_phase(r_state);
    assign done  = (r_state == ST_DONE);
    assign err   = (r_state == ST_ERR);

endmodule

// File: tb/tb_mem_bus_interface.sv
// Scoreboard bench for mem_bus_interface against a behavioral memoryModule.
module tb_mem_bus_interface;

    localparam int TMO = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [15:0] addr  = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic        mfc   = 1'b1;
    logic        busy, done, err, rdM, wrM;
    logic [15:0] rdata, Abus;
    wire  [15:0] Dbus;

    logic [15:0] mem [0:1023];
    logic        probe_en  = 1'b0;
    logic        mem_stuck = 1'b0;
    int          low_cyc   = 4;

    typedef struct packed {
        logic        is_err;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_interface #(
        .ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .Abus(Abus), .Dbus(Dbus), .rdM(rdM), .wrM(wrM), .mfc(mfc)
    );

    // Memory drives read data while rdM is high; otherwise an optional
    // probe pattern shows whether the master has really released the bus.
    assign Dbus = rdM ? mem[Abus[9:0]] : (probe_en ? 16'hA5A5 : 16'hzzzz);

    initial begin
        forever begin
            @(posedge rdM or posedge wrM);
            if (!mem_stuck) begin
                mfc = 1'b0;
                repeat (low_cyc) @(negedge clk);
                if (wrM) mem[Abus[9:0]] = Dbus;
                mfc = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("strobe_exclusive", {31'd0, rdM & wrM}, 32'd0);
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", {30'd0, done, err}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("err_flag", {31'd0, err}, {31'd0, mon_e.is_err});
                    check("done_flag", {31'd0, done}, {31'd0, !mon_e.is_err});
                    check("rdata", {16'd0, rdata}, {16'd0, mon_e.rdata});
                    check("busy_at_end", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic exp_err, input logic [15:0] exp_rd, input logic poke);
        int          cyc;
        int          strobe_cyc;
        logic        seen_wr;
        logic [15:0] prev;
        @(negedge clk);
        req      = 1'b1;
        we       = w;
        addr     = a;
        wdata    = w ? d : 16'hFFFF;
        probe_en = !w;
        exp_q.push_back('{is_err: exp_err, rdata: exp_rd});
        @(negedge clk);
        req   = 1'b0;
        addr  = 16'h0;
        wdata = 16'h0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        cyc        = 0;
        strobe_cyc = 0;
        seen_wr    = 1'b0;
        prev       = 16'h0;
        while (!(done || err) && cyc < 200) begin
            check("abus_hold", {16'd0, Abus}, {16'd0, a});
            if (!w && !rdM) check("dbus_released_rd", {16'd0, Dbus}, 32'h0000A5A5);
            if (w && wrM && !seen_wr) begin
                check("wr_setup_data", {16'd0, prev}, {16'd0, d});
                check("wr_data", {16'd0, Dbus}, {16'd0, d});
                seen_wr = 1'b1;
            end
            if (rdM || wrM) strobe_cyc++;
            if (poke && cyc == 2) begin
                req  = 1'b1;
                addr = 16'd500;
            end else begin
                req  = 1'b0;
                addr = 16'h0;
            end
            prev = Dbus;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) check("completion_timeout", cyc, 0);
        if (w) check("wr_strobe_seen", {31'd0, seen_wr}, 32'd1);
        if (exp_err) check("strobe_cycles_to_err", strobe_cyc, TMO + 1);
        check("strobe_low_at_end", {30'd0, rdM, wrM}, 32'd0);
        if (!w) check("dbus_released_end", {16'd0, Dbus}, 32'h0000A5A5);
        probe_en = 1'b0;
        req      = 1'b0;
        addr     = 16'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        mem[500] = 16'h000F;
        mem[0]   = 16'h818F;
        mem[1]   = 16'h01F4;

        repeat (3) @(negedge clk);
        probe_en = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_strobes", {30'd0, rdM, wrM}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_abus", {16'd0, Abus}, 32'd0);
        check("rst_dbus_released", {16'd0, Dbus}, 32'h0000A5A5);
        probe_en = 1'b0;
        rst_n    = 1'b1;

        access(1'b0, 16'd500, 16'h0,    1'b0, 16'h000F, 1'b0);
        access(1'b1, 16'd600, 16'h1234, 1'b0, 16'h000F, 1'b0);
        access(1'b0, 16'd600, 16'h0,    1'b0, 16'h1234, 1'b0);
        access(1'b0, 16'd0,   16'h0,    1'b0, 16'h818F, 1'b0);
        access(1'b0, 16'd1,   16'h0,    1'b0, 16'h01F4, 1'b0);

        mem_stuck = 1'b1;
        access(1'b0, 16'd500, 16'h0,    1'b1, 16'h01F4, 1'b0);
        mem_stuck = 1'b0;

        // Abort a write while it is waiting for mfc to return high.
        low_cyc = 10;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'd700; wdata = 16'hBEEF;
        @(negedge clk);
        req = 1'b0;
        cyc = 0;
        while (!wrM && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_wr_started", {31'd0, wrM}, 32'd1);
        repeat (5) @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n    = 1'b0;
        probe_en = 1'b1;
        #1;
        check("rst_mid_wrM", {31'd0, wrM}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_dbus", {16'd0, Dbus}, 32'h0000A5A5);
        repeat (2) @(negedge clk);
        probe_en = 1'b0;
        rst_n    = 1'b1;
        repeat (12) @(negedge clk);
        low_cyc = 4;
        check("rst_rdata_cleared", {16'd0, rdata}, 32'd0);

        access(1'b0, 16'd500, 16'h0, 1'b0, 16'h000F, 1'b0);
        access(1'b0, 16'd1,   16'h0, 1'b0, 16'h01F4, 1'b1);

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
